// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer for the combinational alu: accepts one instruction per three cycles,
// supplies operands from a 32x32 register file and writes the ALU result back.
module alu_issue_seq #(
    parameter bit TRAP_ON_OVF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    output logic        instr_ready,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [2:0]  res_flags,
    output logic [4:0]  res_dest,
    output logic        res_wb,
    output logic        res_trap,
    output logic        res_illegal
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] rf [32];
    logic        accept;
    logic [5:0]  op, funct;
    logic [4:0]  dest_d;
    logic        illegal_d, trap_op, trap_d, wb_d;

    assign instr_ready = (state_q == StIdle) && !ld_en;
    assign accept      = instr_valid && instr_ready;
    assign res_valid   = (state_q == StDone);
    assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Destination decode runs on the latched instruction, valid throughout EXEC.
    always_comb begin
        op        = alu_instruction[31:26];
        funct     = alu_instruction[5:0];
        dest_d    = 5'd0;
        illegal_d = 1'b0;
        trap_op   = 1'b0;
        if (op == 6'h00) begin
            case (funct)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B: dest_d = alu_instruction[15:11];
                default:      illegal_d = 1'b1;
            endcase
            trap_op = (funct == 6'h20) || (funct == 6'h22);
        end else begin
            case (op)
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E:
                    dest_d = alu_instruction[20:16];
                6'h23, 6'h2B, 6'h04, 6'h05: dest_d = 5'd0;
                default: illegal_d = 1'b1;
            endcase
            trap_op = (op == 6'h08);
        end
        trap_d = TRAP_ON_OVF && trap_op && alu_flags[2];
        wb_d   = (dest_d != 5'd0) && !trap_d && !illegal_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_instruction <= 32'd0;
            alu_regA        <= 32'd0;
            alu_regB        <= 32'd0;
            res_data        <= 32'd0;
            res_flags       <= 3'd0;
            res_dest        <= 5'd0;
            res_wb          <= 1'b0;
            res_trap        <= 1'b0;
            res_illegal     <= 1'b0;
        end else begin
            if (accept) begin
                alu_instruction <= instr_data;
                alu_regA        <= rf[instr_data[25:21]];
                alu_regB        <= rf[instr_data[20:16]];
            end
            if (state_q == StExec) begin
                res_data    <= alu_result;
                res_flags   <= alu_flags;
                res_dest    <= dest_d;
                res_wb      <= wb_d;
                res_trap    <= trap_d;
                res_illegal <= illegal_d;
            end
        end
    end

    // r0 is never written, so it reads as zero everywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (state_q == StExec) begin
            if (wb_d) rf[dest_d] <= alu_result;
        end else if (state_q == StIdle && ld_en && ld_addr != 5'd0) begin
            rf[ld_addr] <= ld_data;
        end
    end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Instruction issue and writeback sequencer that drives the combinational `alu` block from the producing side. It accepts MIPS instruction words over a valid/ready handshake and reads `rs`/`rt` operands from an internal 32x32 register file. It presents `instruction`/`regA`/`regB` to the ALU, captures `result`/`flags` and writes the result back to `rd` or `rt`. It sits between the instruction source (host or fetch stage) and the ALU, and turns the ALU into a usable datapath.

## Interface
- `TRAP_ON_OVF`, default 1: when 1, add/sub/addi with `alu_flags[2]`=1 suppress writeback and raise `res_trap`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: instruction word offered.
- `instr_data` in 32: MIPS instruction word.
- `instr_ready` out 1: sequencer can accept.
- `ld_en` in 1: host register preload strobe.
- `ld_addr` in 5: preload index.
- `ld_data` in 32: preload value.
- `dbg_addr` in 5: debug read index.
- `dbg_data` out 32: combinational register-file read; `dbg_addr`=0 reads 0.
- `alu_instruction` out 32: to ALU `instruction`.
- `alu_regA` out 32: to ALU `regA` (rs value).
- `alu_regB` out 32: to ALU `regB` (rt value).
- `alu_result` in 32: from ALU `result`.
- `alu_flags` in 3: from ALU `flags`: [2] overflow, [1] less-than, [0] zero.
- `res_valid` out 1: one-cycle completion pulse.
- `res_data` out 32: captured result.
- `res_flags` out 3: captured flags.
- `res_dest` out 5: writeback index; 0 when there is no destination.
- `res_wb` out 1: register file was written.
- `res_trap` out 1: overflow trap.
- `res_illegal` out 1: unsupported encoding.

## Operation
- FSM states and transitions:
  - IDLE → EXEC on accept.
  - EXEC → DONE, unconditionally.
  - DONE → IDLE, unconditionally.
- `instr_ready` = (state==IDLE) && !`ld_en`.
- Accept occurs when `instr_valid` && `instr_ready` at a rising edge. The `alu_*` registers latch `instr_data`, `rf[rs]` and `rf[rt]`.
- Register file:
  - r0 is hardwired to 0; writes to r0 are discarded.
  - Preload writes `rf[ld_addr]` when `ld_en`=1 in IDLE; `ld_en` is ignored in EXEC/DONE.
- Writeback destination:
  - op=0x00 with funct in {00,02,03,04,06,07,20,21,22,23,24,25,26,27,2A,2B} → `rd`=instr[15:11].
  - op in {08,09,0A,0B,0C,0D,0E} → `rt`=instr[20:16].
  - op in {23 lw, 2B sw, 04 beq, 05 bne} → no write; `res_dest`=0, result reported only.
  - Any other op/funct → `res_illegal`=1, no write.
- Overflow trap: when `TRAP_ON_OVF`=1 and the instruction is add (funct 20), sub (funct 22) or addi (op 08) with `alu_flags[2]`=1: `res_trap`=1, `res_wb`=0, register file unchanged. addu/subu/addiu never trap.
- `res_wb` = destination nonzero && !trap && !illegal.
- Outputs hold between pulses: `res_data`/`res_flags`/`res_dest`/`res_wb`/`res_trap`/`res_illegal` keep their last values until the next completion; only `res_valid` pulses.

## Timing
- Reset (async assert, synchronous-safe deassert):
  - State goes to IDLE and all 32 registers clear to 0.
  - All outputs go to 0 (`alu_*`, `res_*`, `res_valid`); `instr_ready` goes to 1.
- Cycle-level sequence:
  - Edge E0 accepts the instruction; `alu_*` are valid for the whole EXEC cycle.
  - Edge E1 captures `alu_result`/`alu_flags` into `res_*` and performs the register-file write. `res_valid`=1 during the DONE cycle (E1 to E2).
  - Edge E2 returns to IDLE; the earliest next accept is E3.
- Throughput and latency: one instruction per 3 cycles; accept-to-`res_valid` latency is 1 cycle.
- Hazards: none. The write completes at E1, before any later operand read.
- `ld_en`=1 in IDLE blocks the accept in that same cycle, so the load always precedes the read.
- With `instr_valid` held high continuously, accepts occur at E0, E3, E6, …
- Reset asserted in EXEC or DONE: the instruction is dropped, no `res_valid` and no write.

## Test plan
- Preload r1=5, r2=1; issue 0x00221820 (add r3,r1,r2) → `alu_regA`=5 and `alu_regB`=1 in EXEC; `res_valid` 1 cycle later with `res_data`=0x00000006, `res_dest`=3, `res_wb`=1; `dbg_addr`=3 reads 6.
- Preload r1=0x7FFFFFFF, r2=1; issue add 0x00221820 → `res_data`=0x80000000, `res_flags`[2]=1, `res_trap`=1, `res_wb`=0, r3 unchanged. Issue addu 0x00221821 with the same operands → `res_wb`=1, r3=0x80000000.
- Preload r1=3; issue 0x20240009 (addi r4,r1,9) → r4=0x0000000C, `res_dest`=4. Issue 0x00220021 (addu r0,r1,r2) → `res_wb`=0, r0 reads 0.
- Issue 0xFC000000 → `res_illegal`=1, `res_wb`=0, register file unchanged. Issue 0x10220004 (beq) → `res_dest`=0, `res_wb`=0.
- Hold `instr_valid`=1 for 10 cycles → accepts exactly every 3rd edge, `instr_ready` low in EXEC/DONE. Assert `ld_en` in IDLE → no accept that cycle.
- Drop `rst_n` during EXEC → outputs zero immediately, no `res_valid`; after release all registers read 0 and `instr_ready`=1.
